branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Front-end branch predictor paired with the execute-stage branch resolver.
- Fetch queries it with a PC and receives a registered taken/target prediction one cycle later.
- Execute returns the resolved outcome (taken flag, target, and the prediction that was used). The block updates a direct-mapped BTB with 2-bit saturating counters and raises a one-cycle mispredict/redirect pulse.

Parameters:
- INDEX_BITS, 6: log2 of BTB entry count (64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8: tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- lk_valid  in  1  lookup request this cycle
- lk_pc  in  32  fetch PC to predict (bits [1:0] ignored)
- pred_valid  out  1  prediction for the previous cycle's lookup is valid
- pred_hit  out  1  lookup matched a valid BTB entry
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  resolved control-flow instruction this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_is_jump  in  1  instruction is jal/jalr (unconditional)
- upd_taken  in  1  resolved taken
- upd_target  in  32  resolved target address
- upd_pred_taken  in  1  pred_taken that fetch used for this instruction
- upd_pred_target  in  32  pred_target that fetch used for this instruction
- mispredict  out  1  one-cycle pulse: prediction was wrong
- redirect_pc  out  32  correct next PC, valid while mispredict=1

Behaviour:
- Entry state: valid, tag[TAG_BITS], target[32], ctr[2], jump[1].
- Reset (rst=1 at an edge):
  - Clear all valid bits.
  - Drive pred_valid, pred_hit, pred_taken, mispredict to 0 and pred_target, redirect_pc to 0.
  - rst overrides any lk_valid or upd_valid in the same cycle; that lookup and update are dropped.
  - Reset mid-operation discards all in-flight results.
- Lookup, 1-cycle latency (registered outputs). At the edge where lk_valid=1:
  - pred_valid <= 1.
  - hit = entry[idx].valid && entry[idx].tag == tag(lk_pc).
  - pred_hit <= hit.
  - pred_taken <= hit && (jump || ctr[1]).
  - pred_target <= pred_taken ? entry.target : lk_pc+4. The add is 32-bit and wraps: 0xFFFFFFFC -> 0x00000000.
- lk_valid=0: pred_valid <= 0, pred_hit <= 0, pred_taken <= 0; pred_target holds its value.
- Read-before-write: a lookup and an update to the same index in the same cycle return the pre-update entry.
- Update, at the edge where upd_valid=1:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not taken, range 0..3 (3+1 = 3, 0-1 = 0). If taken, target <= upd_target.
  - Hit, jump: ctr <= 3, jump <= 1, target <= upd_target.
  - Miss and upd_taken=1: allocate/replace. valid=1, tag, target=upd_target, jump=upd_is_jump, ctr = jump ? 3 : 2 (weakly taken). Evicting an aliasing entry is expected.
  - Miss and upd_taken=0: table unchanged.
- Mispredict, registered, asserted on the cycle after upd_valid:
  - mispredict <= upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc <= upd_taken ? upd_target : upd_pc+4 (wrapping).
  - Pulse width is exactly 1 cycle per update; back-to-back updates give back-to-back independent pulses.
  - redirect_pc holds its value when mispredict=0.
- Lookup and update paths are independent and may be active in the same cycle.
- Table storage needs no reset; only valid bits reset.

Test Plan:
- Reset, then lk_valid=1, lk_pc=0x00000100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x00000104.
- Conditional branch allocation:
  - Stimulus: upd pc=0x100, taken=1, target=0x80, pred_taken=0.
  - Next cycle: mispredict=1, redirect_pc=0x80.
  - Lookup 0x100: hit=1, pred_taken=1 (ctr=2), pred_target=0x80.
- Counter saturation and decay on pc=0x100:
  - Two taken updates (ctr 2->3->3), then one not-taken: ctr=2, still predicts taken.
  - Second not-taken: ctr=1, lookup gives pred_taken=0, pred_target=0x104.
  - Third not-taken: ctr=0, stays 0.
- Jump and wrap:
  - upd_is_jump=1, pc=0x40, target=0x200 -> entry ctr=3, lookup predicts taken to 0x200.
  - Not-taken update at pc=0xFFFFFFFC with pred_taken=1 -> mispredict=1, redirect_pc=0x00000000.
- Alias and same-cycle hazard:
  - Allocate pc=0x100, then taken update at pc=0x100+(1<<(INDEX_BITS+2)) -> replaces the entry; lookup 0x100 now misses.
  - Lookup and update to the same index in one cycle -> prediction reflects the old entry.
- Reset mid-operation:
  - Assert rst the same cycle as upd_valid=1 (mispredicting) and lk_valid=1.
  - Next cycle: mispredict=0, pred_valid=0; all prior entries miss afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: registered fetch-side
// prediction plus execute-side training and a registered mispredict/redirect.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_LSB  = INDEX_BITS + 2;
  localparam int TAG_MSB  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];
  logic [1:0]          ctr_mem    [ENTRIES];
  logic                jump_mem   [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0]   lk_tag, upd_tag;
  logic                  lk_hit, lk_taken, upd_hit;
  logic [31:0]           lk_next;

  // Lookup reads the table before any same-cycle update lands
  always_comb begin
    lk_idx   = lk_pc[INDEX_BITS+1:2];
    lk_tag   = lk_pc[TAG_MSB:TAG_LSB];
    lk_hit   = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_taken = lk_hit && (jump_mem[lk_idx] || ctr_mem[lk_idx][1]);
    lk_next  = lk_taken ? target_mem[lk_idx] : (lk_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= lk_valid;
      pred_hit   <= lk_valid && lk_hit;
      pred_taken <= lk_valid && lk_taken;
      if (lk_valid) pred_target <= lk_next;
    end
  end

  logic        upd_write;
  logic [1:0]  new_ctr;
  logic [31:0] new_target;
  logic        new_jump;

  // Training: hits adjust the counter, taken misses allocate over whatever aliases
  always_comb begin
    upd_idx    = upd_pc[INDEX_BITS+1:2];
    upd_tag    = upd_pc[TAG_MSB:TAG_LSB];
    upd_hit    = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    upd_write  = 1'b0;
    new_ctr    = ctr_mem[upd_idx];
    new_target = target_mem[upd_idx];
    new_jump   = jump_mem[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_is_jump) begin
          new_ctr    = 2'd3;
          new_jump   = 1'b1;
          new_target = upd_target;
        end else if (upd_taken) begin
          new_ctr    = (ctr_mem[upd_idx] == 2'd3) ? 2'd3 : ctr_mem[upd_idx] + 2'd1;
          new_target = upd_target;
        end else begin
          new_ctr    = (ctr_mem[upd_idx] == 2'd0) ? 2'd0 : ctr_mem[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        upd_write  = 1'b1;
        new_jump   = upd_is_jump;
        new_ctr    = upd_is_jump ? 2'd3 : 2'd2;
        new_target = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload storage carries no reset; valid bits alone gate its use
  always_ff @(posedge clk) begin
    if (!rst && upd_write) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= new_target;
      ctr_mem[upd_idx]    <= new_ctr;
      jump_mem[upd_idx]   <= new_jump;
    end
  end

  logic upd_wrong;

  always_comb begin
    upd_wrong = upd_valid &&
                ((upd_taken != upd_pred_taken) ||
                 (upd_taken && (upd_target != upd_pred_target)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= upd_wrong;
      if (upd_wrong) redirect_pc <= upd_taken ? upd_target : (upd_pc + 32'd4);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of the branch predictor: lookup, training, counters,
// jumps, aliasing, same-cycle hazards and reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int compared = 0;
  int mismatched = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later; valids drop afterwards
  task automatic step;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic set_lookup(input logic [31:0] pc);
    lk_valid = 1'b1;
    lk_pc    = pc;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic jmp, input logic tkn,
                            input logic [31:0] tgt, input logic ptkn,
                            input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = jmp;
    upd_taken       = tkn;
    upd_target      = tgt;
    upd_pred_taken  = ptkn;
    upd_pred_target = ptgt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    compared++;
    if ({pred_valid, pred_hit, pred_taken, mispredict} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags got=%b exp=0000", {pred_valid, pred_hit, pred_taken, mispredict});
    end
    compared++;
    if (pred_target !== 32'h0 || redirect_pc !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_addrs got=%h/%h exp=0/0", pred_target, redirect_pc);
    end
    set_lookup(32'h100);
    step();
    compared++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b100 || pred_target !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL cold_lookup got=%b %h exp=100 00000104", {pred_valid, pred_hit, pred_taken}, pred_target);
    end
    step();
    compared++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL idle_hold got=%b %h exp=0 00000104", pred_valid, pred_target);
    end
  endtask

  task automatic test_alloc;
    set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL alloc_mispredict got=%b %h exp=1 00000080", mispredict, redirect_pc);
    end
    set_lookup(32'h100);
    step();
    compared++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL pulse_end got=%b %h exp=0 00000080", mispredict, redirect_pc);
    end
    compared++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b111 || pred_target !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL alloc_lookup got=%b %h exp=111 00000080", {pred_valid, pred_hit, pred_taken}, pred_target);
    end
  endtask

  task automatic test_counter;
    // Right direction, wrong target: still a mispredict
    set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h84);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL target_mispredict got=%b %h exp=1 00000080", mispredict, redirect_pc);
    end
    set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    step();
    compared++;
    if (mispredict !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL correct_pred got=%b exp=0", mispredict);
    end
    set_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL nt_redirect got=%b %h exp=1 00000104", mispredict, redirect_pc);
    end
    set_lookup(32'h100);
    step();
    compared++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL ctr2_lookup got=%b %h exp=1 00000080", pred_taken, pred_target);
    end
    set_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    set_lookup(32'h100);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL ctr1_lookup got=%b %h exp=10 00000104", {pred_hit, pred_taken}, pred_target);
    end
    set_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    step();
    compared++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL nt_correct got=%b %h exp=0 00000104", mispredict, redirect_pc);
    end
    // From a floor of 0, one taken update must still predict not-taken
    set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    set_lookup(32'h100);
    step();
    compared++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL ctr_floor got=%b %h exp=0 00000104", pred_taken, pred_target);
    end
    set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    set_lookup(32'h100);
    step();
    compared++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL ctr_regain got=%b %h exp=1 00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_jump_wrap;
    set_update(32'h40, 1'b1, 1'b1, 32'h200, 1'b0, 32'h44);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL jump_redirect got=%b %h exp=1 00000200", mispredict, redirect_pc);
    end
    set_lookup(32'h40);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL jump_lookup got=%b %h exp=11 00000200", {pred_hit, pred_taken}, pred_target);
    end
    set_update(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234, 1'b1, 32'h1234);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wrap_redirect got=%b %h exp=1 00000000", mispredict, redirect_pc);
    end
    set_lookup(32'hFFFF_FFFC);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b00 || pred_target !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wrap_lookup got=%b %h exp=00 00000000", {pred_hit, pred_taken}, pred_target);
    end
  endtask

  task automatic test_alias;
    set_update(32'h200, 1'b0, 1'b1, 32'h300, 1'b0, 32'h204);
    step();
    set_lookup(32'h100);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b00 || pred_target !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL alias_evict got=%b %h exp=00 00000104", {pred_hit, pred_taken}, pred_target);
    end
    // Same-index lookup and update in one cycle sees the old target
    set_lookup(32'h200);
    set_update(32'h200, 1'b0, 1'b1, 32'h400, 1'b1, 32'h300);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h300) begin
      mismatched++;
      $display("[TB] FAIL same_cycle got=%b %h exp=11 00000300", {pred_hit, pred_taken}, pred_target);
    end
    set_lookup(32'h200);
    step();
    compared++;
    if (pred_target !== 32'h400) begin
      mismatched++;
      $display("[TB] FAIL after_write got=%h exp=00000400", pred_target);
    end
  endtask

  task automatic test_back_to_back;
    set_update(32'h200, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin
      mismatched++;
      $display("[TB] FAIL b2b_first got=%b %h exp=1 00000204", mispredict, redirect_pc);
    end
    set_update(32'h40, 1'b1, 1'b1, 32'h500, 1'b1, 32'h200);
    step();
    compared++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h500) begin
      mismatched++;
      $display("[TB] FAIL b2b_second got=%b %h exp=1 00000500", mispredict, redirect_pc);
    end
    set_update(32'h40, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
    step();
    compared++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h500) begin
      mismatched++;
      $display("[TB] FAIL b2b_third got=%b %h exp=0 00000500", mispredict, redirect_pc);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    set_lookup(32'h40);
    set_update(32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 32'h504);
    step();
    compared++;
    if ({mispredict, pred_valid} !== 2'b00 || redirect_pc !== 32'h0 || pred_target !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset got=%b %h %h exp=00 0 0", {mispredict, pred_valid}, redirect_pc, pred_target);
    end
    set_lookup(32'h40);
    step();
    compared++;
    if ({pred_hit, pred_taken} !== 2'b00 || pred_target !== 32'h44) begin
      mismatched++;
      $display("[TB] FAIL post_reset_40 got=%b %h exp=00 00000044", {pred_hit, pred_taken}, pred_target);
    end
    set_lookup(32'h200);
    step();
    compared++;
    if (pred_hit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_200 got=%b exp=0", pred_hit);
    end
    set_lookup(32'h500);
    step();
    compared++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h504) begin
      mismatched++;
      $display("[TB] FAIL dropped_update got=%b %h exp=0 00000504", pred_hit, pred_target);
    end
  endtask

  initial begin
    rst = 1'b1;
    lk_valid = 1'b0;
    lk_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_is_jump = 1'b0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    step();
    test_reset();
    test_alloc();
    test_counter();
    test_jump_wrap();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
